// File: rtl/hazard_pkg.sv
//==============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hazard_pkg;

    localparam int REG_AW = 2;

    localparam logic [3:0] FWD_REGFILE = 4'b0010;
    localparam logic [2:0] WDSEL_MEM   = 3'd0;
    localparam logic [2:0] WDSEL_SP    = 3'd2;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] dst;
        logic [2:0]        wdsel;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } hz_state_e;

    // A history entry can only feed a consumer if it really writes a forwardable register.
    function automatic logic is_hazard_src(input wb_entry_t e, input logic [REG_AW-1:0] nofwd);
        return e.valid & e.we & (e.dst != nofwd);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_if.sv
//==============================================================================
// Module      : hazard_stall_controller_if
// Description : Decode/EX-side signals exchanged with the hazard controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hazard_stall_controller_if;

    logic                          id_valid;
    logic [hazard_pkg::REG_AW-1:0] id_rd_a;
    logic [hazard_pkg::REG_AW-1:0] id_rd_b;
    logic                          id_use_a;
    logic                          id_use_b;
    logic                          id_we;
    logic                          id_wsel;
    logic [hazard_pkg::REG_AW-1:0] id_wa_a;
    logic [hazard_pkg::REG_AW-1:0] id_wa_b;
    logic [2:0]                    id_wdsel;
    logic                          ex_br_taken;
    logic                          pc_stall;
    logic                          ifid_stall;
    logic                          ifid_flush;
    logic                          idex_bubble;
    logic [3:0]                    fwd_a;
    logic [3:0]                    fwd_b;

    modport master (
        output id_valid, id_rd_a, id_rd_b, id_use_a, id_use_b, id_we, id_wsel,
               id_wa_a, id_wa_b, id_wdsel, ex_br_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rd_a, id_rd_b, id_use_a, id_use_b, id_we, id_wsel,
               id_wa_a, id_wa_b, id_wdsel, ex_br_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b
    );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller_fwd_sel_logic.sv
//==============================================================================
// Module      : fwd_sel_logic
// Description : ALU operand forward select for one source port (EX beats MEM).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_sel_logic
    import hazard_pkg::*;
#(
    parameter int unsigned NOFWD_REG = 3
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  wb_entry_t         ex_entry,
    input  wb_entry_t         mem_entry,
    output logic [3:0]        sel
);

    localparam logic [REG_AW-1:0] c_nofwd = REG_AW'(NOFWD_REG);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = is_hazard_src(ex_entry, c_nofwd)  && (ex_entry.dst  == src);
    assign w_mem_hit = is_hazard_src(mem_entry, c_nofwd) && (mem_entry.dst == src);

    // SP-sourced results are never bypassed; the regfile copy is authoritative.
    always_comb begin
        sel = FWD_REGFILE;
        if (use_src) begin
            if (w_ex_hit) begin
                sel = (ex_entry.wdsel == WDSEL_SP) ? FWD_REGFILE : {1'b0, ex_entry.wdsel};
            end else if (w_mem_hit) begin
                sel = (mem_entry.wdsel == WDSEL_SP) ? FWD_REGFILE : {1'b1, mem_entry.wdsel};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
//==============================================================================
// Module      : hazard_stall_controller
// Description : Load-use stall / branch flush sequencer and forward-select driver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW          = hazard_pkg::REG_AW,
    parameter int unsigned NOFWD_REG       = 3,
    parameter int unsigned LD_STALL_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_stall_controller_if.slave  hz
);

    localparam int unsigned       c_cnt_w = (LD_STALL_CYCLES > 1) ? $clog2(LD_STALL_CYCLES) : 1;
    localparam logic [REG_AW-1:0] c_nofwd = REG_AW'(NOFWD_REG);

    wb_entry_t          r_ex;
    wb_entry_t          r_mem;
    hz_state_e          r_state;
    logic [c_cnt_w-1:0] r_cnt;

    wb_entry_t w_id_entry;
    logic      w_load_use;
    logic      w_stall_hold;
    logic      w_stall;
    logic      w_flush;
    logic      w_bubble;

    assign w_id_entry.valid = 1'b1;
    assign w_id_entry.we    = hz.id_we;
    assign w_id_entry.dst   = hz.id_wsel ? hz.id_wa_b : hz.id_wa_a;
    assign w_id_entry.wdsel = hz.id_wdsel;

    assign w_load_use = hz.id_valid
                      && is_hazard_src(r_ex, c_nofwd)
                      && (r_ex.wdsel == WDSEL_MEM)
                      && ((hz.id_use_a && (r_ex.dst == hz.id_rd_a))
                       || (hz.id_use_b && (r_ex.dst == hz.id_rd_b)));

    // The detect cycle is the first bubble; LDSTALL supplies the remaining count.
    assign w_stall_hold = (r_state == LDSTALL) && (r_cnt != '0);
    assign w_stall      = !hz.ex_br_taken && (w_stall_hold || w_load_use);
    assign w_flush      = hz.ex_br_taken || (r_state == FLUSH);
    assign w_bubble     = w_stall || w_flush;

    assign hz.pc_stall    = w_stall;
    assign hz.ifid_stall  = w_stall;
    assign hz.ifid_flush  = w_flush;
    assign hz.idex_bubble = w_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ex    <= '0;
            r_mem   <= '0;
        end else begin
            r_mem <= r_ex;
            r_ex  <= (w_bubble || !hz.id_valid) ? wb_entry_t'('0) : w_id_entry;
            if (hz.ex_br_taken) begin
                r_state <= FLUSH;
                r_cnt   <= '0;
            end else if (w_stall_hold) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end else if (w_load_use) begin
                r_state <= LDSTALL;
                r_cnt   <= c_cnt_w'(LD_STALL_CYCLES - 1);
            end else begin
                r_state <= RUN;
            end
        end
    end

    fwd_sel_logic #(.NOFWD_REG(NOFWD_REG)) u_fwd_a (
        .src       (hz.id_rd_a),
        .use_src   (hz.id_use_a),
        .ex_entry  (r_ex),
        .mem_entry (r_mem),
        .sel       (hz.fwd_a)
    );

    fwd_sel_logic #(.NOFWD_REG(NOFWD_REG)) u_fwd_b (
        .src       (hz.id_rd_b),
        .use_src   (hz.id_use_b),
        .ex_entry  (r_ex),
        .mem_entry (r_mem),
        .sel       (hz.fwd_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
//==============================================================================
// Module      : tb_hazard_stall_controller
// Description : Vector-table bench for hazard_stall_controller with expected-result queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] rd_a;
        logic [1:0] rd_b;
        logic       use_a;
        logic       use_b;
        logic       we;
        logic       wsel;
        logic [1:0] wa_a;
        logic [1:0] wa_b;
        logic [2:0] wdsel;
        logic       br;
        logic       chk;
        logic [3:0] ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
        logic [3:0] fa;
        logic [3:0] fb;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];
    vec_t exp_q[$];

    hazard_stall_controller_if bus ();

    hazard_stall_controller dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v,
                                input logic [1:0] ra, input logic [1:0] rb,
                                input logic ua, input logic ub, input logic we, input logic ws,
                                input logic [1:0] waa, input logic [1:0] wab,
                                input logic [2:0] wd, input logic br, input logic chk,
                                input logic [3:0] ctl, input logic [3:0] fa, input logic [3:0] fb);
        vec_t x;
        x.rst = r;  x.valid = v;  x.rd_a = ra; x.rd_b = rb;
        x.use_a = ua; x.use_b = ub; x.we = we; x.wsel = ws;
        x.wa_a = waa; x.wa_b = wab; x.wdsel = wd; x.br = br; x.chk = chk;
        x.ctl = ctl; x.fa = fa; x.fb = fb;
        return x;
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t       e;
        logic [3:0] got_ctl;
        @(posedge clk);
        #1;
        rst             = v.rst;
        bus.id_valid    = v.valid;
        bus.id_rd_a     = v.rd_a;
        bus.id_rd_b     = v.rd_b;
        bus.id_use_a    = v.use_a;
        bus.id_use_b    = v.use_b;
        bus.id_we       = v.we;
        bus.id_wsel     = v.wsel;
        bus.id_wa_a     = v.wa_a;
        bus.id_wa_b     = v.wa_b;
        bus.id_wdsel    = v.wdsel;
        bus.ex_br_taken = v.br;
        if (v.chk) exp_q.push_back(v);
        @(negedge clk);
        if (v.chk) begin
            e       = exp_q.pop_front();
            got_ctl = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble};
            checks++;
            if (got_ctl !== e.ctl || bus.fwd_a !== e.fa || bus.fwd_b !== e.fb) begin
                errors++;
                $display("FAIL %s: got ctl=%b fwd_a=%b fwd_b=%b, expected ctl=%b fwd_a=%b fwd_b=%b",
                         name, got_ctl, bus.fwd_a, bus.fwd_b, e.ctl, e.fa, e.fb);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_rd_a = '0; bus.id_rd_b = '0;
        bus.id_use_a = 1'b0; bus.id_use_b = 1'b0; bus.id_we = 1'b0; bus.id_wsel = 1'b0;
        bus.id_wa_a = '0; bus.id_wa_b = '0; bus.id_wdsel = '0; bus.ex_br_taken = 1'b0;
        repeat (3) @(posedge clk);

        //               r  v  ra rb ua ub we ws waa wab wd br chk ctl      fa       fb
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // reset state
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // ADD r1
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0001)); // EX ALU fwd
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b1001, 4'b1001)); // MEM ALU fwd
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 2, 1, 3, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // IN r1 (B field)
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 4, 0, 1, 4'b0000, 4'b0011, 4'b0010)); // LDI r1, unused B
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0100, 4'b0010)); // EX wins over MEM
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // write r3
        tbl.push_back(mk(0, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // r3 never fwd
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // SP-sourced r0
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // LDD r2, SP no fwd
        tbl.push_back(mk(0, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b1101, 4'b0000, 4'b0010)); // load-use stall
        tbl.push_back(mk(0, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b1000, 4'b0010)); // after bubble
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // idle
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010)); // LDD r1
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010)); // invalid id: no stall

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // branch taken in the load-use detect cycle
        apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010), "br_ldd");
        apply(mk(0, 1, 0, 2, 0, 1, 1, 0, 1, 0, 1, 1, 1, 4'b0011, 4'b0010, 4'b0000), "br_detect");
        apply(mk(0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0011, 4'b0010, 4'b1000), "br_flush_state");
        apply(mk(0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010), "br_done");

        // reset while a load-use stall is in progress
        apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010), "rst_ldd");
        apply(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000), "rst_pulse");
        apply(mk(0, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0010), "rst_after");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
